// File: rtl/fadd_pkg.sv
// Shared types and constants for the single-precision add datapath.
//   fp32_t        : IEEE-754 single-precision field view
//   FP32_*        : encoding constants
//   FLG_*         : bit positions in the {nan, inf, ovf} sticky flag vector
//   accum_state_e : fadd_accum_seq controller states
package fadd_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;

    localparam int unsigned FLG_OVF = 0;
    localparam int unsigned FLG_INF = 1;
    localparam int unsigned FLG_NAN = 2;

    // ACC_EXEC_R is only reachable when the adder output register is built in.
    typedef enum logic [1:0] {
        ACC_IDLE   = 2'd0,
        ACC_EXEC_R = 2'd1,
        ACC_EXEC   = 2'd2,
        ACC_DONE   = 2'd3
    } accum_state_e;

endpackage

// File: rtl/fp32_class.sv
// Combinational NaN / infinity classifier for a single-precision word.
// Ports:
//   word   : 32-bit IEEE-754 single-precision value
//   is_nan : exponent all ones, mantissa non-zero
//   is_inf : exponent all ones, mantissa zero
module fp32_class
    import fadd_pkg::*;
(
    input  logic [31:0] word,
    output logic        is_nan,
    output logic        is_inf
);

    fp32_t w;
    logic  unused_sign;

    assign w           = fp32_t'(word);
    assign unused_sign = w.sign;

    assign is_nan = (w.exp == FP32_EXP_MAX) && (w.mant != 23'd0);
    assign is_inf = (w.exp == FP32_EXP_MAX) && (w.mant == 23'd0);

endmodule

// File: rtl/fadd_accum_seq.sv
// Packet sum controller wrapped around an external combinational fp32 adder.
// Elements arrive on in_* (valid/ready); in_last closes a packet and its sum,
// saturated element count and sticky {nan, inf, ovf} flags leave on out_*.
// fadd_a/fadd_b drive the adder straight from the accumulator and operand
// registers; fadd_res/fadd_ovf come back combinationally.
// Build option: FADD_OUT_REG_EN inserts a register stage on the adder result
// (extra ACC_EXEC_R state), costing one cycle per element.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : element handshake; in_data, in_last
//   fadd_a, fadd_b           : adder operands
//   fadd_res, fadd_ovf       : adder result and overflow
//   out_valid/out_ready      : sum handshake; out_sum, out_count, out_flags
module fadd_accum_seq
    import fadd_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      fadd_a,
    output logic [31:0]      fadd_b,
    input  logic [31:0]      fadd_res,
    input  logic             fadd_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_flags
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    accum_state_e     state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       flags_q, flags_d;

    logic [31:0]      sum_src;
    logic             ovf_src;
    logic             nan_r, inf_r;
    logic [2:0]       new_flags;

`ifdef FADD_OUT_REG_EN
    logic [31:0]      res_q, res_d;
    logic             ovf_q, ovf_d;

    assign sum_src = res_q;
    assign ovf_src = ovf_q;
`else
    assign sum_src = fadd_res;
    assign ovf_src = fadd_ovf;
`endif

    fp32_class u_class (
        .word   (sum_src),
        .is_nan (nan_r),
        .is_inf (inf_r)
    );

    always_comb begin
        new_flags          = 3'b000;
        new_flags[FLG_NAN] = nan_r;
        new_flags[FLG_INF] = inf_r;
        new_flags[FLG_OVF] = ovf_src;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_b_d    = op_b_q;
        last_d    = last_q;
        count_d   = count_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef FADD_OUT_REG_EN
        res_d     = res_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ACC_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_b_d  = in_data;
                    last_d  = in_last;
`ifdef FADD_OUT_REG_EN
                    state_d = ACC_EXEC_R;
`else
                    state_d = ACC_EXEC;
`endif
                end
            end
`ifdef FADD_OUT_REG_EN
            ACC_EXEC_R: begin
                res_d   = fadd_res;
                ovf_d   = fadd_ovf;
                state_d = ACC_EXEC;
            end
`endif
            ACC_EXEC: begin
                acc_d   = sum_src;
                flags_d = flags_q | new_flags;
                // Count saturates; the sum keeps accumulating regardless.
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                state_d = last_q ? ACC_DONE : ACC_IDLE;
            end
            ACC_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = FP32_POS_ZERO;
                    count_d = '0;
                    flags_d = 3'b000;
                    state_d = ACC_IDLE;
                end
            end
            default: begin
                state_d = ACC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC_IDLE;
            acc_q   <= FP32_POS_ZERO;
            op_b_q  <= 32'h0000_0000;
            last_q  <= 1'b0;
            count_q <= '0;
            flags_q <= 3'b000;
`ifdef FADD_OUT_REG_EN
            res_q   <= 32'h0000_0000;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_b_q  <= op_b_d;
            last_q  <= last_d;
            count_q <= count_d;
            flags_q <= flags_d;
`ifdef FADD_OUT_REG_EN
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign fadd_a    = acc_q;
    assign fadd_b    = op_b_q;
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign out_flags = flags_q;

endmodule

// File: tb/tb_fadd_accum_seq.sv
module tb_fadd_accum_seq;

    localparam int unsigned CNT_W = 3;
    localparam int          BUDGET = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic [31:0]      fadd_a;
    logic [31:0]      fadd_b;
    logic [31:0]      fadd_res;
    logic             fadd_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic [2:0]       out_flags;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0]      sum;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       flg;
    } exp_t;

    exp_t sb[$];

    logic [31:0]      m_acc;
    logic [CNT_W-1:0] m_cnt;
    logic [2:0]       m_flg;

    always #5 clk = ~clk;

    fadd_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .fadd_a    (fadd_a),
        .fadd_b    (fadd_b),
        .fadd_res  (fadd_res),
        .fadd_ovf  (fadd_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_flags (out_flags)
    );

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    // Reference single-precision adder, round-to-nearest-even; {ovf, result}.
    function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        int          ex, ey, d, e;
        logic [27:0] mx, my, s;
        logic [24:0] mr;
        logic        sticky;
        x = a;
        y = b;
        if (is_nan(x) || is_nan(y)) return {1'b0, 32'h7FC0_0000};
        if (is_inf(x) && is_inf(y) && (x[31] != y[31])) return {1'b0, 32'h7FC0_0000};
        if (is_inf(x)) return {1'b0, x};
        if (is_inf(y)) return {1'b0, y};
        if (x[30:0] < y[30:0]) begin
            t = x;
            x = y;
            y = t;
        end
        ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = ex - ey;
        if (d > 26) begin
            my = {27'd0, my != 28'd0};
        end else if (d > 0) begin
            sticky = |(my & ((28'd1 << d) - 28'd1));
            my     = (my >> d) | {27'd0, sticky};
        end
        s = (x[31] == y[31]) ? (mx + my) : (mx - my);
        if (s == 28'd0) return {1'b0, 32'h0000_0000};
        e = ex;
        if (s[27]) begin
            s = (s >> 1) | {27'd0, s[0]};
            e = e + 1;
        end else begin
            while (!s[26] && e > 1) begin
                s = s << 1;
                e = e - 1;
            end
        end
        if (!s[26]) e = 0;
        mr = {1'b0, s[26:3]};
        if (s[2] && ((|s[1:0]) || s[3])) begin
            mr = mr + 25'd1;
            if (mr[24]) begin
                mr = mr >> 1;
                e  = e + 1;
            end
        end
        if (e == 0 && mr[23]) e = 1;
        if (e >= 255) return {1'b1, x[31], 8'hFF, 23'd0};
        t = {x[31], 8'(e), mr[22:0]};
        return {1'b0, t};
    endfunction

    assign {fadd_ovf, fadd_res} = fp_add(fadd_a, fadd_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        $error("FAIL %s: timeout after %0d cycles", tag, BUDGET);
    endtask

    task automatic model_clear();
        m_acc = 32'h0;
        m_cnt = '0;
        m_flg = 3'b000;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int          n;
        logic [32:0] r;
        exp_t        e;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            timeout("in_ready");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        r        = fp_add(m_acc, d);
        m_acc    = r[31:0];
        m_flg    = m_flg | {is_nan(r[31:0]), is_inf(r[31:0]), r[32]};
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (l) begin
            e.sum = m_acc;
            e.cnt = m_cnt;
            e.flg = m_flg;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Waits for out_valid, pops the scoreboard and compares; leaves DUT in DONE.
    task automatic collect(input string tag, output exp_t e);
        int n;
        n = 0;
        e.sum = 32'h0;
        e.cnt = '0;
        e.flg = 3'b000;
        while (!out_valid && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            timeout({tag, "_out_valid"});
            return;
        end
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s: output with empty scoreboard, observed sum %h", tag, out_sum);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, out_sum, e.sum);
        chk({tag, "_count"}, 32'(out_count), 32'(e.cnt));
        chk({tag, "_flags"}, 32'(out_flags), 32'(e.flg));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fadd_a", fadd_a, 32'h0);
        chk("rst_fadd_b", fadd_b, 32'h0);

        // 1.0 + 2.0 + 0.5 = 3.5
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h3F00_0000, 1'b1);
        collect("p1", e);
        chk("p1_sum_const", out_sum, 32'h4060_0000);
        consume();
        chk("p1_idle_in_ready", 32'(in_ready), 32'd1);
        chk("p1_idle_out_valid", 32'(out_valid), 32'd0);

        // Single element, then a lone -0 which must come back as +0.
        send(32'hC049_0FDB, 1'b1);
        collect("p2", e);
        chk("p2_sum_const", out_sum, 32'hC049_0FDB);
        consume();
        send(32'h8000_0000, 1'b1);
        collect("p3", e);
        chk("p3_sum_const", out_sum, 32'h0000_0000);
        consume();

        // Overflow to infinity, then flags must not leak into the next packet.
        send(32'h7F7F_FFFF, 1'b0);
        send(32'h7F7F_FFFF, 1'b1);
        collect("p4", e);
        chk("p4_flags_const", 32'(out_flags), 32'd3);
        consume();
        send(32'h3F80_0000, 1'b1);
        collect("p5", e);
        chk("p5_flags_clear", 32'(out_flags), 32'd0);
        consume();

        // NaN in the middle of a packet.
        send(32'h3F80_0000, 1'b0);
        send(32'h7FC0_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        collect("p6", e);
        chk("p6_exp", 32'(out_sum[30:23]), 32'hFF);
        chk("p6_mant_nz", 32'(out_sum[22:0] != 23'd0), 32'd1);
        chk("p6_nan_flag", 32'(out_flags[2]), 32'd1);
        consume();

        // Backpressure: hold DONE for 5 cycles with a pending element.
        out_ready = 1'b0;
        send(32'h3F80_0000, 1'b0);
        send(32'h4080_0000, 1'b1);
        collect("p7", e);
        in_valid = 1'b1;
        in_data  = 32'h4120_0000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", out_sum, e.sum);
            chk("bp_count", 32'(out_count), 32'(e.cnt));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_no_consume", fadd_b, 32'h4080_0000);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        chk("bp_rel_acc", fadd_a, 32'h0);

        // Reset while the second element is in EXEC.
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("mid_rst_acc", fadd_a, 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        send(32'h3F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        collect("p8", e);
        chk("p8_count_const", 32'(out_count), 32'd2);
        consume();

        // Nine elements: count saturates at 7, sum keeps going to 9.0.
        for (int i = 0; i < 9; i++) send(32'h3F80_0000, i == 8);
        collect("p9", e);
        chk("p9_count_sat", 32'(out_count), 32'd7);
        chk("p9_sum_const", out_sum, 32'h4110_0000);
        consume();

        n_chk++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL sb_empty: observed %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
